w0rm_ready_buffer: RTL and testbench

- Valid/ready elastic buffer for the W0RM pipeline; the backward-path counterpart of the forward data/valid register stage.
- Registers the ready path so a long upstream ready fan-in is cut, while still sustaining one transfer per cycle.
- Built as a small circular FIFO with registered input_ready, output_valid and data storage.
- Placed between producer and consumer pipeline stages wherever ready timing is critical.

---
 rtl/w0rm_ready_buffer_pkg.sv | 30 +++
 rtl/w0rm_ready_buffer_mem.sv | 37 +++
 rtl/w0rm_ready_buffer.sv | 108 ++++++++++
 tb/tb_w0rm_ready_buffer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/w0rm_ready_buffer_pkg.sv
// -----------------------------------------------------------------------------
// w0rm_ready_buffer_pkg
// Shared constants and helpers for the W0RM ready-path elastic buffer.
//   ptr_width()  - constant clog2 used to size pointers from DEPTH
//   is_pow2()    - constant check that DEPTH is a power of two
//   ZERO_FILL    - value driven on payload outputs when no word is valid
// -----------------------------------------------------------------------------
package w0rm_ready_buffer_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 4;

    // Payload outputs are forced to this value when no word is presented.
    localparam logic ZERO_FILL = 1'b0;

    // Smallest w with 2**w >= depth. Evaluated at elaboration only.
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/w0rm_ready_buffer_mem.sv
// -----------------------------------------------------------------------------
// w0rm_ready_buffer_mem
// DEPTH x DATA_WIDTH register array: one synchronous write port, one
// combinational read port.
//   clk     in   clock, write on posedge
//   wr_en   in   write strobe
//   wr_addr in   write index
//   wr_data in   write payload
//   rd_addr in   read index
//   rd_data out  mem[rd_addr], combinational
// -----------------------------------------------------------------------------
module w0rm_ready_buffer_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; an entry is only ever read after it was
    // written, because output_valid is gated by the (reset) occupancy count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/w0rm_ready_buffer.sv
// -----------------------------------------------------------------------------
// w0rm_ready_buffer
// Valid/ready elastic buffer that registers input_ready, cutting the upstream
// ready fan-in while sustaining one transfer per cycle. Circular FIFO.
//   clk           in   clock, all state on posedge
//   reset         in   synchronous active-high reset
//   input_valid   in   upstream word valid
//   input_ready   out  registered; a word is accepted this cycle if valid
//   input_data    in   upstream payload
//   output_ready  in   downstream can accept
//   output_valid  out  at least one word buffered
//   output_data   out  head-of-queue word, zero when output_valid=0
//   level         out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module w0rm_ready_buffer
    import w0rm_ready_buffer_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEFAULT_DEPTH,
    localparam int unsigned ADDR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  output_ready,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head_data;

    assign output_valid = (count_q != '0);
    assign push         = input_valid & in_ready_q;
    assign pop          = output_valid & output_ready;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Ready looks only at next occupancy, never at output_ready, so the
        // downstream ready path never reaches input_ready combinationally.
        // The price is a one-cycle bubble when a pop happens while full.
        in_ready_d = (count_d < COUNT_FULL);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
        end
    end

    w0rm_ready_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (input_data),
        .rd_addr (rd_ptr_q),
        .rd_data (head_data)
    );

    assign input_ready = in_ready_q;
    assign output_data = output_valid ? head_data : {DATA_WIDTH{ZERO_FILL}};
    assign level       = count_q;

endmodule

// File: tb/tb_w0rm_ready_buffer.sv
// -----------------------------------------------------------------------------
// tb_w0rm_ready_buffer
// Directed and random-backpressure bench for w0rm_ready_buffer (DEPTH=4).
// A queue model tracks the expected contents, level and registered ready.
// -----------------------------------------------------------------------------
module tb_w0rm_ready_buffer;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  input_valid;
    logic                  input_ready;
    logic [DATA_WIDTH-1:0] input_data;
    logic                  output_ready;
    logic                  output_valid;
    logic [DATA_WIDTH-1:0] output_data;
    logic [ADDR_WIDTH:0]   level;

    w0rm_ready_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_ready (output_ready),
        .output_valid (output_valid),
        .output_data  (output_data),
        .level        (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [DATA_WIDTH-1:0] model_q [$];
    logic                  ready_m = 1'b0;
    logic                  hold_prev = 1'b0;
    logic [DATA_WIDTH-1:0] data_prev = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs against the model,
    // then advance the model across the edge. Entered and left at posedge+1.
    task automatic cycle(input string tag, input logic v, input logic [DATA_WIDTH-1:0] d,
                         input logic r);
        logic push_m, pop_m;
        logic [DATA_WIDTH-1:0] head_m;
        input_valid  = v;
        input_data   = d;
        output_ready = r;
        #1;
        head_m = (model_q.size() != 0) ? model_q[0] : '0;
        check({tag, " level"}, 64'(level), 64'(model_q.size()));
        check({tag, " out_valid"}, 64'(output_valid), 64'(model_q.size() != 0));
        check({tag, " out_data"}, 64'(output_data), 64'(head_m));
        check({tag, " in_ready"}, 64'(input_ready), 64'(ready_m));
        if (hold_prev) begin
            check({tag, " stable"}, 64'(output_data), 64'(data_prev));
        end
        push_m    = v & ready_m;
        pop_m     = (model_q.size() != 0) & r;
        hold_prev = output_valid & ~r & ~reset;
        data_prev = output_data;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            ready_m   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (pop_m)  void'(model_q.pop_front());
            if (push_m) model_q.push_back(d);
            ready_m = (model_q.size() < DEPTH);
        end
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for 3 cycles, then released.
        for (int i = 0; i < 3; i++) cycle("reset", 1'b1, 32'hDEAD, 1'b1);
        check("reset in_ready", 64'(input_ready), 64'd0);
        check("reset level", 64'(level), 64'd0);
        reset = 1'b0;
        cycle("release", 1'b0, '0, 1'b0);
        check("release in_ready", 64'(input_ready), 64'd1);

        // Fill to full with downstream stalled.
        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 32'hA0 + i, 1'b0);
        check("full level", 64'(level), 64'd4);
        check("full in_ready", 64'(input_ready), 64'd0);
        for (int i = 0; i < 2; i++) cycle("full_hold", 1'b1, 32'hA4, 1'b0);
        check("full no_accept level", 64'(level), 64'd4);
        check("full head", 64'(output_data), 64'hA0);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            check("drain order", 64'(output_data), 64'(32'hA0 + i));
            cycle("drain", 1'b0, '0, 1'b1);
            if (i == 0) check("drain ready back", 64'(input_ready), 64'd1);
        end
        check("drained valid", 64'(output_valid), 64'd0);
        check("drained data", 64'(output_data), 64'd0);

        // Streaming: one word per cycle after one cycle of fill latency.
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                check("stream data", 64'(output_data), 64'(i - 1));
                check("stream level", 64'(level), 64'd1);
            end
            cycle("stream", 1'b1, DATA_WIDTH'(i), 1'b1);
        end
        check("stream last", 64'(output_data), 64'd99);
        cycle("stream_tail", 1'b0, '0, 1'b1);
        check("stream empty", 64'(output_valid), 64'd0);

        // Random valid/ready at 50%.
        for (int i = 0; i < 10000; i++) begin
            cycle("random", 1'($urandom_range(0, 1)), DATA_WIDTH'($urandom),
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle("rand_drain", 1'b0, '0, 1'b1);
        check("rand_drain empty", 64'(level), 64'd0);

        // Reset in the middle of traffic with three words buffered.
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 32'hC0 + i, 1'b0);
        check("pre_rst level", 64'(level), 64'd3);
        reset = 1'b1;
        cycle("mid_rst", 1'b1, 32'hEE, 1'b0);
        reset = 1'b0;
        check("mid_rst level", 64'(level), 64'd0);
        check("mid_rst valid", 64'(output_valid), 64'd0);
        cycle("post_rst", 1'b0, '0, 1'b0);
        cycle("push55", 1'b1, 32'h55, 1'b0);
        check("post_rst first valid", 64'(output_valid), 64'd1);
        check("post_rst first word", 64'(output_data), 64'h55);
        cycle("pop55", 1'b0, '0, 1'b1);
        check("post_rst empty", 64'(output_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
